aes_encrypt_iter: RTL and testbench

//  Iterative AES-128/192/256 encryption core: one round per clock, key schedule expanded once per key

---
 rtl/aes_encrypt_iter.sv | 242 ++++++++++++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_encrypt_iter
//   Iterative AES-128/192/256 encryption core. A cipher key is expanded once,
//   one schedule word per clock, into an internal word store. Any number of
//   plaintext blocks can then be encrypted under that key, one round per clock.
//
//   Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. Ready outputs depend only on the FSM state, except in_ready
//   in S_IDLE, which is also low while key_valid is high (a key wins over a
//   block in the same cycle). Inputs are only sampled on a transfer.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   key_valid  / key_ready / key_in[Nk*32]   key channel, w[0] in the top word
//   in_valid   / in_ready  / data_in[128]    plaintext channel, byte 0 = MSB
//   out_valid  / out_ready / data_out[128]   ciphertext channel
//   busy       high while expanding the key or running rounds
// ---------------------------------------------------------------------------
module aes_encrypt_iter #(
   parameter int Nk = 4,
   parameter int Nb = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [Nk*32-1:0]  key_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [127:0]      data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [127:0]      data_out,
   output logic              busy
);
   localparam int Nr = Nk + 6;
   localparam int NW = Nb * (Nr + 1);
   localparam int IW = $clog2(NW);

   if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
      $error("aes_encrypt_iter: Nk must be 4, 6 or 8");
   end
   if (Nb != 4) begin : g_bad_nb
      $error("aes_encrypt_iter: only Nb = 4 is supported");
   end

   typedef enum logic [2:0] {S_NOKEY, S_KEXP, S_IDLE, S_ROUND, S_DONE} state_e;

   // ---------------- GF(2^8) helpers ----------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box computed as inverse (x^254, so 0 maps to 0) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] sq;
      logic [7:0] e;
      r  = 8'h01;
      sq = x;
      e  = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, sq);
         sq = gf_mul(sq, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // SubBytes + ShiftRows (+ MixColumns unless last). Byte k sits at row k%4, column k/4.
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
      logic [7:0]   b [16];
      logic [7:0]   r [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int k = 0; k < 16; k++) b[k] = sbox(s[127-8*k -: 8]);
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            r[4*c+rr] = b[4*((c+rr)%4)+rr];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = r[4*c];
         a1 = r[4*c+1];
         a2 = r[4*c+2];
         a3 = r[4*c+3];
         if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
         else      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return o;
   endfunction

   // ---------------- state ----------------
   state_e          state_q, state_d;
   logic [127:0]    blk_q, blk_d;
   logic [127:0]    data_out_q, data_out_d;
   logic [3:0]      round_q, round_d;
   logic [IW-1:0]   kidx_q, kidx_d;    // schedule word being produced
   logic [2:0]      kpos_q, kpos_d;    // kidx_q mod Nk, tracked incrementally
   logic [7:0]      rcon_q, rcon_d;
   logic [31:0]     w_q [NW];
   logic            key_load, w_we;

   // ---------------- key expansion datapath ----------------
   logic [31:0] prev_w, back_w, tmp_w, new_w;
   always_comb begin
      prev_w = w_q[kidx_q - IW'(1)];
      back_w = w_q[kidx_q - IW'(Nk)];
      tmp_w  = prev_w;
      if (kpos_q == 3'd0)
         tmp_w = sub_word({prev_w[23:0], prev_w[31:24]}) ^ {rcon_q, 24'h0};
      else if (Nk == 8 && kpos_q == 3'd4)
         tmp_w = sub_word(prev_w);
      new_w = back_w ^ tmp_w;
   end

   // ---------------- round datapath ----------------
   logic [IW-1:0] rk_base;
   logic [127:0]  rk, init_key, round_out;
   always_comb begin
      rk_base   = IW'({round_q, 2'b00});
      rk        = {w_q[rk_base], w_q[rk_base + IW'(1)], w_q[rk_base + IW'(2)], w_q[rk_base + IW'(3)]};
      init_key  = {w_q[0], w_q[1], w_q[2], w_q[3]};
      round_out = aes_round(blk_q, round_q == 4'(Nr)) ^ rk;
   end

   // ---------------- FSM next state / outputs ----------------
   always_comb begin
      state_d    = state_q;
      blk_d      = blk_q;
      data_out_d = data_out_q;
      round_d    = round_q;
      kidx_d     = kidx_q;
      kpos_d     = kpos_q;
      rcon_d     = rcon_q;
      key_ready  = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      key_load   = 1'b0;
      w_we       = 1'b0;
      case (state_q)
         S_NOKEY: begin
            key_ready = 1'b1;
            if (key_valid) begin
               key_load = 1'b1;
               kidx_d   = IW'(Nk);
               kpos_d   = 3'd0;
               rcon_d   = 8'h01;
               state_d  = S_KEXP;
            end
         end
         S_KEXP: begin
            busy   = 1'b1;
            w_we   = 1'b1;
            kpos_d = (kpos_q == 3'(Nk-1)) ? 3'd0 : kpos_q + 3'd1;
            if (kpos_q == 3'd0) rcon_d = xtime(rcon_q);
            if (kidx_q == IW'(NW-1)) state_d = S_IDLE;
            else                     kidx_d  = kidx_q + IW'(1);
         end
         S_IDLE: begin
            key_ready = 1'b1;
            in_ready  = ~key_valid;
            if (key_valid) begin
               key_load = 1'b1;
               kidx_d   = IW'(Nk);
               kpos_d   = 3'd0;
               rcon_d   = 8'h01;
               state_d  = S_KEXP;
            end else if (in_valid) begin
               blk_d   = data_in ^ init_key;
               round_d = 4'd1;
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            busy  = 1'b1;
            blk_d = round_out;
            if (round_q == 4'(Nr)) begin
               data_out_d = round_out;
               state_d    = S_DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_NOKEY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_NOKEY;
         blk_q      <= '0;
         data_out_q <= '0;
         round_q    <= '0;
         kidx_q     <= '0;
         kpos_q     <= '0;
         rcon_q     <= 8'h01;
      end else begin
         state_q    <= state_d;
         blk_q      <= blk_d;
         data_out_q <= data_out_d;
         round_q    <= round_d;
         kidx_q     <= kidx_d;
         kpos_q     <= kpos_d;
         rcon_q     <= rcon_d;
      end
   end

   // Key word store; validity is carried by the FSM (S_NOKEY after reset).
   always_ff @(posedge clk) begin
      if (key_load) begin
         for (int i = 0; i < Nk; i++) w_q[i] <= key_in[Nk*32-1-32*i -: 32];
      end
      if (w_we) w_q[kidx_q] <= new_w;
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_encrypt_iter
//   Directed bench for aes_encrypt_iter with one instance per key size
//   (index 0: Nk=4, 1: Nk=6, 2: Nk=8). Expected ciphertexts are known-answer
//   vectors pushed into exp_q when a block is accepted and popped when the
//   ciphertext is taken.
// ---------------------------------------------------------------------------
module tb_aes_encrypt_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         key_valid [3];
   logic         key_ready [3];
   logic [255:0] key_in    [3];
   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [127:0] data_in   [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [127:0] data_out  [3];
   logic         busy      [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int NK = 4 + 2*g;
      aes_encrypt_iter #(.Nk(NK), .Nb(4)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .key_valid (key_valid[g]),
         .key_ready (key_ready[g]),
         .key_in    (key_in[g][NK*32-1:0]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .data_in   (data_in[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .data_out  (data_out[g]),
         .busy      (busy[g])
      );
   end

   int           n_cmp  = 0;
   int           n_fail = 0;
   logic [127:0] exp_q [$];

   localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY_B = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_B4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_B6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_B8 = 128'h8ea2b7ca516745bfeafc49904b496089;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a key, wait for its transfer, then time the expansion.
   task automatic load_key(input int n, input logic [255:0] key, input int exp_cycles);
      int cnt;
      key_in[n]    = key;
      key_valid[n] = 1'b1;
      #1;
      cnt = 0;
      while (!key_ready[n] && cnt < 200) begin tick(); cnt++; end
      check($sformatf("dut%0d key_ready", n), 128'(key_ready[n]), 128'd1);
      tick();
      key_valid[n] = 1'b0;
      cnt = 0;
      while (busy[n] && cnt < 200) begin tick(); cnt++; end
      check($sformatf("dut%0d expansion cycles", n), 128'(cnt), 128'(exp_cycles));
   endtask

   // Present a block and wait for its transfer; record the expected ciphertext.
   task automatic send_block(input int n, input logic [127:0] pt, input logic [127:0] exp,
                             input bit push);
      int cnt;
      data_in[n]  = pt;
      in_valid[n] = 1'b1;
      #1;
      cnt = 0;
      while (!in_ready[n] && cnt < 300) begin tick(); cnt++; end
      check($sformatf("dut%0d in_ready", n), 128'(in_ready[n]), 128'd1);
      tick();
      in_valid[n] = 1'b0;
      if (push) exp_q.push_back(exp);
   endtask

   // Wait for out_valid (counting edges since the accept edge), take the result.
   task automatic recv(input int n, input int nr, input string tag);
      int           lat;
      logic [127:0] exp;
      lat = 0;
      while (!out_valid[n] && lat < 100) begin tick(); lat++; end
      check({tag, " latency"}, 128'(lat), 128'(nr));
      out_ready[n] = 1'b1;
      check({tag, " scoreboard has entry"}, 128'(exp_q.size() > 0), 128'd1);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         check({tag, " ciphertext"}, data_out[n], exp);
      end
      tick();
      out_ready[n] = 1'b0;
      check({tag, " out_valid drops"}, 128'(out_valid[n]), 128'd0);
      check({tag, " back to idle"}, 128'(in_ready[n]), 128'd1);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [127:0] hold_exp;
      int           lat;
      bit           rose;

      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         key_valid[i] = 1'b0;
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b0;
         key_in[i]    = '0;
         data_in[i]   = '0;
      end
      tick();
      tick();

      // Reset state of every instance
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dut%0d reset key_ready", i), 128'(key_ready[i]), 128'd1);
         check($sformatf("dut%0d reset in_ready", i),  128'(in_ready[i]),  128'd0);
         check($sformatf("dut%0d reset out_valid", i), 128'(out_valid[i]), 128'd0);
         check($sformatf("dut%0d reset data_out", i),  data_out[i],        128'd0);
         check($sformatf("dut%0d reset busy", i),      128'(busy[i]),      128'd0);
      end
      rst = 1'b1;
      tick();

      // AES-192 and AES-256 known answers
      load_key(1, KEY_B[255:64], 46);
      send_block(1, PT_B, CT_B6, 1'b1);
      recv(1, 12, "aes192");
      load_key(2, KEY_B, 52);
      send_block(2, PT_B, CT_B8, 1'b1);
      recv(2, 14, "aes256");

      // AES-128 known answer
      load_key(0, 256'(KEY_A), 40);
      send_block(0, PT_A, CT_A, 1'b1);
      recv(0, 10, "aes128 fips");

      // Three blocks under one key, no re-expansion in between
      load_key(0, KEY_B[255:128], 40);
      for (int b = 0; b < 3; b++) begin
         check($sformatf("multi blk%0d idle not busy", b), 128'(busy[0]), 128'd0);
         send_block(0, PT_B, CT_B4, 1'b1);
         recv(0, 10, $sformatf("multi blk%0d", b));
      end

      // Output back-pressure for 20 cycles
      send_block(0, PT_B, CT_B4, 1'b1);
      lat = 0;
      while (!out_valid[0] && lat < 100) begin tick(); lat++; end
      check("hold latency", 128'(lat), 128'd10);
      hold_exp = exp_q[0];
      for (int c = 0; c < 20; c++) begin
         check($sformatf("hold c%0d out_valid", c), 128'(out_valid[0]), 128'd1);
         check($sformatf("hold c%0d data_out", c),  data_out[0],        hold_exp);
         check($sformatf("hold c%0d in_ready", c),  128'(in_ready[0]),  128'd0);
         check($sformatf("hold c%0d key_ready", c), 128'(key_ready[0]), 128'd0);
         tick();
      end
      recv(0, 0, "hold release");

      // Key and block offered together in S_IDLE: key wins, block follows
      key_in[0]    = 256'(KEY_A);
      data_in[0]   = PT_A;
      key_valid[0] = 1'b1;
      in_valid[0]  = 1'b1;
      #1;
      check("collide in_ready", 128'(in_ready[0]), 128'd0);
      check("collide key_ready", 128'(key_ready[0]), 128'd1);
      tick();
      key_valid[0] = 1'b0;
      check("collide expanding", 128'(busy[0]), 128'd1);
      check("collide in_ready during kexp", 128'(in_ready[0]), 128'd0);
      send_block(0, PT_A, CT_A, 1'b1);
      recv(0, 10, "collide new key");

      // Reset during round 5 aborts the block
      send_block(0, PT_B, 128'd0, 1'b0);
      repeat (4) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("abort key_ready", 128'(key_ready[0]), 128'd1);
      check("abort in_ready",  128'(in_ready[0]),  128'd0);
      check("abort out_valid", 128'(out_valid[0]), 128'd0);
      check("abort busy",      128'(busy[0]),      128'd0);
      check("abort data_out",  data_out[0],        128'd0);
      rose = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid[0]) rose = 1'b1;
         tick();
      end
      check("abort out_valid never rises", 128'(rose), 128'd0);
      load_key(0, 256'(KEY_A), 40);
      send_block(0, PT_A, CT_A, 1'b1);
      recv(0, 10, "after abort");

      check("scoreboard drained", 128'(exp_q.size()), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
